// File: rtl/mdu_seq_if.sv
// Handshake and data bundle between the E-stage pipeline and the multiply/divide unit.
interface mdu_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        md_d;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] rd_data;

  modport master (
    output start, op, a, b, rd_sel, md_d,
    input  busy, done, stall, rd_data
  );

  modport slave (
    input  start, op, a, b, rd_sel, md_d,
    output busy, done, stall, rd_data
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// The result is computed at issue and held in a pending register until the busy window expires.
module mdu_seq #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic      clk,
  input logic      reset,
  mdu_seq_if.slave bus
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYC);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYC);

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic        done_q;

  logic [63:0] mul_s, mul_u;
  logic        is_signed, neg_a, neg_b;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi_d, res_lo_d;

  // Signed divide works on magnitudes so the INT_MIN / -1 case wraps cleanly.
  always_comb begin
    mul_s     = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    mul_u     = {32'b0, bus.a} * {32'b0, bus.b};
    is_signed = (bus.op == 3'd2);
    neg_a     = is_signed & bus.a[31];
    neg_b     = is_signed & bus.b[31];
    a_mag     = neg_a ? -bus.a : bus.a;
    b_mag     = neg_b ? -bus.b : bus.b;
    q_mag     = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag     = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    quo       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem       = neg_a ? -r_mag : r_mag;
    // Divide by zero re-commits the current HI/LO, i.e. leaves them unchanged.
    res_hi_d  = hi_q;
    res_lo_d  = lo_q;
    case (bus.op)
      3'd0: {res_hi_d, res_lo_d} = mul_s;
      3'd1: {res_hi_d, res_lo_d} = mul_u;
      3'd2, 3'd3: begin
        if (bus.b != 32'd0) begin
          res_hi_d = rem;
          res_lo_d = quo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              3'd0, 3'd1: begin
                res_hi_q <= res_hi_d;
                res_lo_q <= res_lo_d;
                cnt_q    <= MultCnt;
                state_q  <= StRun;
              end
              3'd2, 3'd3: begin
                res_hi_q <= res_hi_d;
                res_lo_q <= res_lo_d;
                cnt_q    <= DivCnt;
                state_q  <= StRun;
              end
              3'd4:    hi_q <= bus.a;
              3'd5:    lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        StRun: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = done_q;
  assign bus.stall   = bus.md_d & (bus.start | bus.busy);
  assign bus.rd_data = bus.rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized bench for mdu_seq against an arithmetic HI/LO model.
module tb_mdu_seq;

  localparam int unsigned MultCyc = 5;
  localparam int unsigned DivCyc  = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_seq_if bus ();

  mdu_seq #(
    .MULT_CYC (MultCyc),
    .DIV_CYC  (DivCyc)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // HI/LO effect of one accepted operation, using native 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin pu = ua * ub; hi = pu[63:32]; lo = pu[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      3'd3: if (b != 0) begin lo = a / b; hi = a % b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  task automatic read_check(input string tag, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
    bus.rd_sel = 1'b0;
    #1 check({tag, "_hi"}, bus.rd_data, exp_hi);
    bus.rd_sel = 1'b1;
    #1 check({tag, "_lo"}, bus.rd_data, exp_lo);
  endtask

  // Caller positions time at a falling edge; returns at a falling edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic md, input bit inj);
    int          n, cyc;
    logic [31:0] old_hi, old_lo;
    old_hi     = m_hi;
    old_lo     = m_lo;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.a      = a;
    bus.b      = b;
    bus.md_d   = md;
    #1 check("stall_issue", bus.stall, md);
    model(op, a, b, m_hi, m_lo);
    @(negedge clk);
    bus.start = 1'b0;
    if (op <= 3'd3) begin
      n   = (op < 3'd2) ? MultCyc : DivCyc;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 40) begin
        if (inj && cyc == 2) begin
          bus.start = 1'b1;
          bus.op    = 3'd4;
          bus.a     = 32'hDEAD_BEEF;
        end else begin
          bus.start = 1'b0;
        end
        #1 check("stall_busy", bus.stall, md);
        check("done_busy", bus.done, 1'b0);
        read_check("old", old_hi, old_lo);
        cyc++;
        @(negedge clk);
      end
      bus.start = 1'b0;
      #1 check("busy_len", cyc, n);
      check("done_pulse", bus.done, 1'b1);
      check("stall_after", bus.stall, 1'b0);
      read_check("commit", m_hi, m_lo);
      @(negedge clk);
      #1 check("done_clear", bus.done, 1'b0);
      @(negedge clk);
    end else begin
      #1 check("busy_nb", bus.busy, 1'b0);
      check("done_nb", bus.done, 1'b0);
      read_check("nb", m_hi, m_lo);
      @(negedge clk);
    end
    bus.md_d = 1'b0;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    bus.rd_sel = 1'b0;
    bus.md_d   = 1'b0;
    repeat (2) @(negedge clk);

    #1 check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    read_check("rst", 32'd0, 32'd0);
    bus.md_d  = 1'b1;
    #1 check("rst_stall0", bus.stall, 1'b0);
    bus.start = 1'b1;
    #1 check("rst_stall1", bus.stall, 1'b1);
    bus.start = 1'b0;
    bus.md_d  = 1'b0;

    // Start presented right at release must be taken on the first rising edge.
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi", m_hi, 32'hFFFF_FFFF);
    check("mult_lo", m_lo, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(3'd6, 32'h5555_5555, 32'd1, 1'b1, 1'b0);

    // Back-to-back mthi / mtlo.
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'h1234_5678;
    model(3'd4, 32'h1234_5678, 32'd0, m_hi, m_lo);
    @(negedge clk);
    bus.op = 3'd5;
    bus.a  = 32'h9ABC_DEF0;
    #1 check("mthi_busy", bus.busy, 1'b0);
    bus.rd_sel = 1'b0;
    #1 check("mthi_rd", bus.rd_data, 32'h1234_5678);
    model(3'd5, 32'h9ABC_DEF0, 32'd0, m_hi, m_lo);
    @(negedge clk);
    bus.start = 1'b0;
    #1 check("mtlo_busy", bus.busy, 1'b0);
    check("mtlo_done", bus.done, 1'b0);
    read_check("mtx", 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);

    run_op(3'd2, 32'd100, 32'd7, 1'b1, 1'b1);

    // Asynchronous reset in busy cycle 2 drops the pending result.
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'h0001_2345;
    bus.b     = 32'h0000_6789;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 check("pre_rst_busy", bus.busy, 1'b1);
    reset = 1'b0;
    #1 check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    read_check("mid_rst", 32'd0, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) begin
      @(negedge clk);
      #1 check("rst_no_done", bus.done, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1 check("post_rst_done", bus.done, 1'b0);
    @(negedge clk);
    run_op(3'd0, 32'h0001_2345, 32'h0000_6789, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu (legal range 1..15).
REQ-002 The block SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu (legal range 1..15).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Ports are clk and reset.
REQ-004 Port: clk, input, 1, rising-edge clock for all state.
REQ-005 Port: reset, input, 1, asynchronous active-low reset.
REQ-006 Port: start, input, 1, E-stage MDU operation valid this cycle.
REQ-007 Port: op, input, 3, operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
REQ-008 Port: a, input, 32, rs operand.
REQ-009 Port: b, input, 32, rt operand.
REQ-010 Port: rd_sel, input, 1, read select: 0 HI, 1 LO.
REQ-011 Port: md_d, input, 1, D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-012 Port: busy, output, 1, an operation is in flight.
REQ-013 Port: done, output, 1, one-cycle pulse after HI/LO commit.
REQ-014 Port: stall, output, 1, pipeline stall request.
REQ-015 Port: rd_data, output, 32, selected committed HI or LO.

Function
REQ-016 The block SHALL keep state: hi, lo, res_hi, res_lo (pending result), a 4-bit down-counter cnt, a done flag, and a two-state FSM IDLE/RUN.
REQ-017 In IDLE, start=1 with op 0..3 SHALL compute the result into res_hi/res_lo at that edge, load cnt with MULT_CYC (ops 0/1) or DIV_CYC (ops 2/3), and go to RUN.
REQ-018 mult SHALL produce the signed 64-bit product; multu SHALL produce the unsigned product; {res_hi,res_lo} = {product[63:32], product[31:0]}.
REQ-019 div/divu SHALL set res_lo = quotient and res_hi = remainder; signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-020 For b=0, the divide SHALL still occupy DIV_CYC cycles and SHALL leave hi/lo unchanged at commit.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL commit lo=0x80000000 and hi=0.
REQ-022 In RUN, cnt SHALL decrement by 1 every edge; at the edge where cnt==1, hi/lo SHALL take res_hi/res_lo, cnt SHALL go to 0, the FSM SHALL go to IDLE, and done SHALL be set.
REQ-023 busy SHALL equal (FSM==RUN); busy SHALL be high for exactly MULT_CYC or DIV_CYC cycles, starting the cycle after start.
REQ-024 done SHALL be high for exactly the one cycle after commit and low otherwise.
REQ-025 In IDLE, start with op 4 SHALL write hi=a at that edge, and op 5 SHALL write lo=a; neither SHALL assert busy or done.
REQ-026 start with op 6/7 SHALL change no state.
REQ-027 start while busy=1 SHALL be ignored: no restart, no mthi/mtlo write, no result change.
REQ-028 rd_data SHALL be combinational: rd_sel ? lo : hi, from committed registers only. During RUN it SHALL show the old values.
REQ-029 stall SHALL be combinational: md_d & (start | busy).
REQ-030 When start and md_d are both high in IDLE, stall SHALL be high in that cycle and the start SHALL still be accepted.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for clk, force hi=0, lo=0, res_hi=0, res_lo=0, cnt=0, FSM=IDLE, done=0.
REQ-032 While reset=0, the outputs SHALL be busy=0, done=0, rd_data=0, and stall=md_d&start.
REQ-033 Reset asserted mid-operation SHALL discard the pending result; hi/lo SHALL read 0 after reset deasserts.
REQ-034 The first start SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-035 mult a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-036 multu a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE; rd_data shows the old values while busy.
REQ-037 div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 -> hi/lo unchanged after 10 cycles.
REQ-038 mthi a=0x12345678 then mtlo a=0x9ABCDEF0 in consecutive cycles -> busy stays 0; rd_sel=0 gives 0x12345678 and rd_sel=1 gives 0x9ABCDEF0 from the next cycle.
REQ-039 md_d=1 during a div -> stall=1 for all 10 busy cycles and 0 after; a start issued in busy cycle 3 is ignored and the original result commits.
REQ-040 reset pulled low during busy cycle 2 of a mult -> busy=0 and hi=lo=0 immediately; no done pulse; the next mult after release runs normally.
